// File: rtl/cla_accumulator.sv
// Operand-stream accumulator wrapped around an external 16-bit carry-lookahead adder.
// Holds the adder operands steady for SETTLE_CYCLES, then folds the sum and carry into a wide running total.
module cla_accumulator #(
  parameter int ACC_W         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic [15:0]      add_x,
  output logic [15:0]      add_y,
  input  logic [15:0]      add_s,
  input  logic             add_co
);

  // state  | meaning
  // IDLE   | waiting for an operand
  // SETTLE | operands held on the adder until its outputs are stable
  // DONE   | packet total presented downstream
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t            state, state_nxt;
  logic [CW-1:0]     settle_cnt;
  logic [15:0]       op_reg;
  logic              last_reg;
  logic [ACC_W-1:0]  acc;
  logic [7:0]        count;
  logic              ovf;
  logic              accept, sample, release_pkt;
  logic [ACC_W-17:0] acc_hi_nxt;

  assign accept      = (state == IDLE) && in_valid;
  assign sample      = (state == SETTLE) && (settle_cnt == '0);
  assign release_pkt = (state == DONE) && out_ready;

  // The adder has no carry-in, so the upper half is advanced by its carry-out alone.
  assign acc_hi_nxt = acc[ACC_W-1:16] + (ACC_W-16)'(add_co);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE:  if (sample) state_nxt = last_reg ? DONE : IDLE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      op_reg     <= '0;
      last_reg   <= 1'b0;
      acc        <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      if (accept) begin
        op_reg     <= in_data;
        last_reg   <= in_last;
        settle_cnt <= CW'(SETTLE_CYCLES - 1);
      end else if ((state == SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - 1'b1;
      end

      if (sample) begin
        acc <= {acc_hi_nxt, add_s};
        if ((&acc[ACC_W-1:16]) && add_co) ovf <= 1'b1;
        if (count != 8'hFF) count <= count + 8'd1;
      end else if (release_pkt) begin
        acc   <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end
    end
  end

  assign add_x     = op_reg;
  assign add_y     = acc[15:0];
  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_cla_accumulator.sv
// Drives one stimulus stream into a 32-bit and a 17-bit accumulator, each with its own behavioural adder,
// and checks both against a packet-level model of the running total.
module tb_cla_accumulator;
  localparam int SETTLE = 2;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic [15:0] in_data = '0;
  logic        in_last = 0;
  logic        out_ready = 0;

  logic        rdy32, vld32, ovf32;
  logic [31:0] sum32;
  logic [7:0]  cnt32;
  logic [15:0] ax32, ay32, as32;
  logic        aco32;

  logic        rdy17, vld17, ovf17;
  logic [16:0] sum17;
  logic [7:0]  cnt17;
  logic [15:0] ax17, ay17, as17;
  logic        aco17;

  assign {aco32, as32} = {1'b0, ax32} + {1'b0, ay32};
  assign {aco17, as17} = {1'b0, ax17} + {1'b0, ay17};

  cla_accumulator #(.ACC_W(32), .SETTLE_CYCLES(SETTLE)) d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_data(in_data),
    .in_last(in_last), .out_valid(vld32), .out_ready(out_ready), .out_sum(sum32),
    .out_count(cnt32), .out_ovf(ovf32), .add_x(ax32), .add_y(ay32),
    .add_s(as32), .add_co(aco32));

  cla_accumulator #(.ACC_W(17), .SETTLE_CYCLES(SETTLE)) d17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy17), .in_data(in_data),
    .in_last(in_last), .out_valid(vld17), .out_ready(out_ready), .out_sum(sum17),
    .out_count(cnt17), .out_ovf(ovf17), .add_x(ax17), .add_y(ay17),
    .add_s(as17), .add_co(aco17));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // packet-level model: unbounded true sum, wrapped per width only when compared
  longint run_sum = 0;
  int     run_cnt = 0;
  longint pkt_sum = 0;
  int     pkt_cnt = 0;
  bit     pending = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (vld32) begin
        if (!pending) chk("spurious_valid32", 1, 0);
        else begin
          chk("sum32", longint'(sum32), pkt_sum & 64'hFFFF_FFFF);
          chk("count32", longint'(cnt32), longint'(pkt_cnt));
          chk("ovf32", longint'(ovf32), longint'(pkt_sum >= 64'h1_0000_0000));
        end
      end
      if (vld17) begin
        if (!pending) chk("spurious_valid17", 1, 0);
        else begin
          chk("sum17", longint'(sum17), pkt_sum & 64'h1_FFFF);
          chk("count17", longint'(cnt17), longint'(pkt_cnt));
          chk("ovf17", longint'(ovf17), longint'(pkt_sum >= 64'h2_0000));
        end
      end
    end
  end

  task automatic model_accept(input logic [15:0] d, input bit last);
    run_sum += longint'(d);
    run_cnt = (run_cnt < 255) ? run_cnt + 1 : 255;
    if (last) begin
      pkt_sum = run_sum;
      pkt_cnt = run_cnt;
      pending = 1;
      run_sum = 0;
      run_cnt = 0;
    end
  endtask

  task automatic send(input logic [15:0] d, input bit last);
    int n;
    @(negedge clk);
    in_valid = 1; in_data = d; in_last = last;
    n = 0;
    while (!rdy32 && n < 20) begin @(negedge clk); n++; end
    if (!rdy32) chk("ready_timeout", 0, 1);
    @(posedge clk);
    model_accept(d, last);
    #1;
    in_valid = 0; in_last = 0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(last ? vld32 : rdy32) && n < 20);
    chk(last ? "last_to_valid_cycles" : "ready_low_cycles", n, SETTLE);
    chk("ready_match", rdy17, rdy32);
  endtask

  task automatic finish_pkt(input logic [31:0] s32, input logic [16:0] s17,
                            input int cnt, input bit o17);
    chk("pin_valid", vld32 & vld17, 1);
    chk("pin_sum32", sum32, s32);
    chk("pin_sum17", sum17, s17);
    chk("pin_count", cnt32, cnt);
    chk("pin_ovf32", ovf32, 0);
    chk("pin_ovf17", ovf17, o17);
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    pending = 0;
    #1;
    chk("release_valid", vld32 | vld17, 0);
    chk("release_ready", rdy32 & rdy17, 1);
    out_ready = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("rst_valid", vld32 | vld17, 0);
    chk("rst_sum", sum32 | 32'(sum17), 0);
    chk("rst_count", cnt32 | cnt17, 0);
    chk("rst_ovf", ovf32 | ovf17, 0);
    chk("rst_addxy", ax32 | ay32 | ax17 | ay17, 0);
    chk("rst_ready", rdy32 & rdy17, 1);

    send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 1);
    finish_pkt(32'h6, 17'h6, 3, 0);

    send(16'hFFFF, 0); send(16'h0001, 1);
    finish_pkt(32'h0001_0000, 17'h1_0000, 2, 0);

    send(16'hFFFF, 0); send(16'hFFFF, 0); send(16'h0002, 1);
    finish_pkt(32'h0002_0000, 17'h0, 3, 1);

    // backpressure with a stray operand offered while the total is held
    send(16'h0100, 1);
    @(negedge clk);
    in_valid = 1; in_data = 16'h00AA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", rdy32 | rdy17, 0);
      chk("bp_sum_hold", sum32, 32'h100);
    end
    in_valid = 0;
    finish_pkt(32'h100, 17'h100, 1, 0);
    send(16'h0005, 1);
    finish_pkt(32'h5, 17'h5, 1, 0);

    // reset during SETTLE drops the operand
    @(negedge clk);
    in_valid = 1; in_data = 16'h1234; in_last = 0;
    @(posedge clk);
    #1;
    in_valid = 0;
    rst = 1;
    run_sum = 0; run_cnt = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("midrst_sum", sum32, 0);
    send(16'h0007, 1);
    finish_pkt(32'h7, 17'h7, 1, 0);

    // count saturation
    for (int i = 0; i < 256; i++) send(16'h0001, i == 255);
    finish_pkt(32'h100, 17'h100, 255, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
